// File: rtl/scenario_sequencer.sv
// Scenario sequencer: queues 5-bit scenario IDs and launches each one on a
// state_in/start interface, then reports completion or timeout per launch.
module scenario_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 3200,
  parameter int unsigned GAP_CYCLES   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [4:0] push_id,
  output logic       full,
  output logic       empty,
  output logic       drop_err,
  output logic       start,
  output logic [4:0] state_in,
  input  logic       done_in,
  output logic       busy,
  output logic       result_valid,
  output logic [4:0] result_id,
  output logic       result_timeout
);

  localparam int unsigned IDW  = 5;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CMAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             start_q, start_d;
  logic [IDW-1:0]   state_in_q, state_in_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic [IDW-1:0]   result_id_q, result_id_d;
  logic             result_timeout_q, result_timeout_d;

  logic [IDW-1:0]   mem_q [DEPTH];
  logic [IDW-1:0]   mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             drop_err_q, drop_err_d;

  logic             pop;
  logic             push_ok;
  logic [IDW-1:0]   head;

  // Queue: a pop frees a slot in the same cycle, so a full queue still accepts
  always_comb begin
    pop        = (state_q == S_IDLE) && !empty_q;
    push_ok    = push && (push_id != IDW'(0)) && (!full_q || pop);
    head       = mem_q[rd_ptr_q];
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_err_d = push && !push_ok;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CNTW'(push_ok) - CNTW'(pop);
    full_d  = (count_d == CNTW'(DEPTH));
    empty_d = (count_d == CNTW'(0));
  end

  // Launch FSM: next state and registered outputs
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    timer_d          = timer_q;
    start_d          = start_q;
    state_in_d       = state_in_q;
    result_valid_d   = 1'b0;
    result_id_d      = result_id_q;
    result_timeout_d = result_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_in_d = head;
          start_d    = 1'b1;
          cnt_d      = '0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          start_d = 1'b0;
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        // done_in has priority over an expiry on the same cycle
        if (done_in) begin
          result_valid_d   = 1'b1;
          result_timeout_d = 1'b0;
          result_id_d      = state_in_q;
          cnt_d            = '0;
          state_d          = S_GAP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          result_valid_d   = 1'b1;
          result_timeout_d = 1'b1;
          result_id_d      = state_in_q;
          cnt_d            = '0;
          state_d          = S_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      timer_q          <= '0;
      start_q          <= 1'b0;
      state_in_q       <= '0;
      busy_q           <= 1'b0;
      result_valid_q   <= 1'b0;
      result_id_q      <= '0;
      result_timeout_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      full_q           <= 1'b0;
      empty_q          <= 1'b1;
      drop_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      timer_q          <= timer_d;
      start_q          <= start_d;
      state_in_q       <= state_in_d;
      busy_q           <= busy_d;
      result_valid_q   <= result_valid_d;
      result_id_q      <= result_id_d;
      result_timeout_q <= result_timeout_d;
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      full_q           <= full_d;
      empty_q          <= empty_d;
      drop_err_q       <= drop_err_d;
    end
  end

  assign full           = full_q;
  assign empty          = empty_q;
  assign drop_err       = drop_err_q;
  assign start          = start_q;
  assign state_in       = state_in_q;
  assign busy           = busy_q;
  assign result_valid   = result_valid_q;
  assign result_id      = result_id_q;
  assign result_timeout = result_timeout_q;

endmodule

// File: tb/tb_scenario_sequencer.sv
// Directed bench for scenario_sequencer with short timing parameters.
module tb_scenario_sequencer;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned START_CYCLES = 2;
  localparam int unsigned TIMEOUT      = 16;
  localparam int unsigned GAP_CYCLES   = 4;
  localparam int          LIMIT        = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push = 1'b0;
  logic [4:0] push_id = 5'd0;
  logic       done_in = 1'b0;
  logic       full, empty, drop_err, start, busy;
  logic       result_valid, result_timeout;
  logic [4:0] state_in, result_id;

  int n_cmp = 0;
  int n_err = 0;

  scenario_sequencer #(
    .DEPTH(DEPTH), .START_CYCLES(START_CYCLES),
    .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .push_id(push_id),
    .full(full), .empty(empty), .drop_err(drop_err), .start(start),
    .state_in(state_in), .done_in(done_in), .busy(busy),
    .result_valid(result_valid), .result_id(result_id),
    .result_timeout(result_timeout)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the selected output equals val; n = edges taken (LIMIT if never)
  task automatic wait_for(input int sel, input logic val, output int n);
    logic cur;
    n = 0;
    forever begin
      case (sel)
        0:       cur = start;
        1:       cur = result_valid;
        default: cur = busy;
      endcase
      if (cur === val || n >= LIMIT) break;
      tick();
      n++;
    end
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic push_one(input logic [4:0] id);
    push = 1'b1;
    push_id = id;
    tick();
    push = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if ({start, busy, full, empty, drop_err, result_valid, result_timeout} !== 7'b0001000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0001000",
        {start, busy, full, empty, drop_err, result_valid, result_timeout}); end
    n_cmp++; if ({state_in, result_id} !== 10'd0) begin
      n_err++; $display("FAIL reset_ids: got %h want 0", {state_in, result_id}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    push_one(5'd1);
    n_cmp++; if ({start, empty} !== 2'b00) begin
      n_err++; $display("FAIL basic_latency1: start,empty got %b want 00", {start, empty}); end
    tick();
    n_cmp++; if ({start, state_in, busy} !== {1'b1, 5'd1, 1'b1}) begin
      n_err++; $display("FAIL basic_launch: got %b/%0d/%b want 1/1/1", start, state_in, busy); end
    wait_for(0, 1'b0, n);
    n_cmp++; if (n !== START_CYCLES) begin
      n_err++; $display("FAIL basic_start_len: got %0d want %0d", n, START_CYCLES); end
    repeat (4) tick();
    pulse_done();
    n_cmp++; if ({result_valid, result_id, result_timeout} !== {1'b1, 5'd1, 1'b0}) begin
      n_err++; $display("FAIL basic_result: got %b/%0d/%b want 1/1/0",
        result_valid, result_id, result_timeout); end
    tick();
    n_cmp++; if ({result_valid, result_id} !== {1'b0, 5'd1}) begin
      n_err++; $display("FAIL basic_rv_pulse: got %b/%0d want 0/1", result_valid, result_id); end
    wait_for(2, 1'b0, n);
    n_cmp++; if (n !== GAP_CYCLES - 1) begin
      n_err++; $display("FAIL basic_gap: got %0d want %0d", n, GAP_CYCLES - 1); end
    n_cmp++; if (state_in !== 5'd1) begin
      n_err++; $display("FAIL basic_state_hold: got %0d want 1", state_in); end
  endtask

  task automatic test_timeout();
    int n;
    push_one(5'd9);
    tick();
    n_cmp++; if ({start, state_in} !== {1'b1, 5'd9}) begin
      n_err++; $display("FAIL to_launch: got %b/%0d want 1/9", start, state_in); end
    wait_for(0, 1'b0, n);
    wait_for(1, 1'b1, n);
    n_cmp++; if (n !== TIMEOUT) begin
      n_err++; $display("FAIL to_latency: got %0d want %0d", n, TIMEOUT); end
    n_cmp++; if ({result_id, result_timeout} !== {5'd9, 1'b1}) begin
      n_err++; $display("FAIL to_result: got %0d/%b want 9/1", result_id, result_timeout); end
    wait_for(2, 1'b0, n);
    n_cmp++; if (n !== GAP_CYCLES) begin
      n_err++; $display("FAIL to_gap: got %0d want %0d", n, GAP_CYCLES); end
  endtask

  task automatic test_queue_limits();
    int n;
    logic seen;
    logic [4:0] ids [4] = '{5'd10, 5'd3, 5'd4, 5'd5};
    push_one(5'd2);
    tick();
    n_cmp++; if ({start, state_in, empty} !== {1'b1, 5'd2, 1'b1}) begin
      n_err++; $display("FAIL q_launch2: got %b/%0d/%b want 1/2/1", start, state_in, empty); end
    for (int i = 0; i < 4; i++) push_one(ids[i]);
    n_cmp++; if (full !== 1'b1) begin
      n_err++; $display("FAIL q_full: got %b want 1", full); end
    push_one(5'd6);
    n_cmp++; if ({drop_err, full} !== 2'b11) begin
      n_err++; $display("FAIL q_drop_full: got %b want 11", {drop_err, full}); end
    tick();
    n_cmp++; if (drop_err !== 1'b0) begin
      n_err++; $display("FAIL q_drop_pulse: got %b want 0", drop_err); end
    pulse_done();
    n_cmp++; if (result_id !== 5'd2) begin
      n_err++; $display("FAIL q_rid2: got %0d want 2", result_id); end
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 1'b1, n);
      n_cmp++; if ({n[7:0], state_in} !== {8'(GAP_CYCLES + 1), ids[i]}) begin
        n_err++; $display("FAIL q_order%0d: got %0d after %0d want %0d after %0d",
          i, state_in, n, ids[i], GAP_CYCLES + 1); end
      wait_for(0, 1'b0, n);
      pulse_done();
      n_cmp++; if ({result_valid, result_id} !== {1'b1, ids[i]}) begin
        n_err++; $display("FAIL q_result%0d: got %b/%0d want 1/%0d", i, result_valid, result_id, ids[i]); end
    end
    wait_for(2, 1'b0, n);
    seen = 1'b0;
    repeat (10) begin tick(); if (start) seen = 1'b1; end
    n_cmp++; if ({seen, empty} !== 2'b01) begin
      n_err++; $display("FAIL q_no6: start_seen,empty got %b want 01", {seen, empty}); end
    push_one(5'd0);
    n_cmp++; if ({drop_err, empty} !== 2'b11) begin
      n_err++; $display("FAIL q_id0_drop: got %b want 11", {drop_err, empty}); end
    seen = 1'b0;
    repeat (8) begin tick(); if (start) seen = 1'b1; end
    n_cmp++; if ({seen, drop_err} !== 2'b00) begin
      n_err++; $display("FAIL q_id0_nolaunch: got %b want 00", {seen, drop_err}); end
  endtask

  task automatic test_simultaneous();
    int n;
    logic [4:0] ids [4] = '{5'd12, 5'd13, 5'd14, 5'd15};
    push_one(5'd7);
    tick();
    wait_for(0, 1'b0, n);
    repeat (TIMEOUT - 1) tick();
    n_cmp++; if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL sim_early_rv: got %b want 0", result_valid); end
    pulse_done();
    n_cmp++; if ({result_valid, result_id, result_timeout} !== {1'b1, 5'd7, 1'b0}) begin
      n_err++; $display("FAIL sim_done_wins: got %b/%0d/%b want 1/7/0",
        result_valid, result_id, result_timeout); end
    push_one(5'd11);
    for (int i = 0; i < 3; i++) push_one(ids[i]);
    n_cmp++; if ({full, busy, start} !== 3'b100) begin
      n_err++; $display("FAIL sim_full_idle: got %b want 100", {full, busy, start}); end
    push_one(5'd15);
    n_cmp++; if ({drop_err, full, start, state_in} !== {3'b011, 5'd11}) begin
      n_err++; $display("FAIL sim_push_on_pop: got %b/%b/%b/%0d want 0/1/1/11",
        drop_err, full, start, state_in); end
    wait_for(0, 1'b0, n);
    pulse_done();
    for (int i = 0; i < 4; i++) begin
      wait_for(0, 1'b1, n);
      n_cmp++; if (state_in !== ids[i]) begin
        n_err++; $display("FAIL sim_order%0d: got %0d want %0d", i, state_in, ids[i]); end
      wait_for(0, 1'b0, n);
      pulse_done();
    end
    wait_for(2, 1'b0, n);
    n_cmp++; if ({empty, result_id} !== {1'b1, 5'd15}) begin
      n_err++; $display("FAIL sim_drain: got %b/%0d want 1/15", empty, result_id); end
  endtask

  task automatic test_reset_mid_launch();
    logic seen;
    push_one(5'd3);
    push_one(5'd4);
    n_cmp++; if ({start, state_in} !== {1'b1, 5'd3}) begin
      n_err++; $display("FAIL rst_pre: got %b/%0d want 1/3", start, state_in); end
    #4;
    reset = 1'b0;
    #1;
    n_cmp++; if ({start, state_in, empty, busy, full} !== {1'b0, 5'd0, 3'b100}) begin
      n_err++; $display("FAIL rst_async: got %b/%0d/%b%b%b want 0/0/100",
        start, state_in, empty, busy, full); end
    tick(); tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin tick(); if (start) seen = 1'b1; end
    n_cmp++; if ({seen, empty, busy} !== 3'b010) begin
      n_err++; $display("FAIL rst_no_start: got %b want 010", {seen, empty, busy}); end
  endtask

  task automatic test_back_to_back();
    int n;
    push_one(5'd1);
    push_one(5'd2);
    n_cmp++; if ({start, state_in} !== {1'b1, 5'd1}) begin
      n_err++; $display("FAIL b2b_first: got %b/%0d want 1/1", start, state_in); end
    wait_for(0, 1'b0, n);
    repeat (3) tick();
    pulse_done();
    n_cmp++; if ({result_valid, result_id} !== {1'b1, 5'd1}) begin
      n_err++; $display("FAIL b2b_res1: got %b/%0d want 1/1", result_valid, result_id); end
    for (int i = 0; i < int'(GAP_CYCLES); i++) begin
      tick();
      n_cmp++; if ({start, state_in} !== {1'b0, 5'd1}) begin
        n_err++; $display("FAIL b2b_gap%0d: got %b/%0d want 0/1", i, start, state_in); end
    end
    tick();
    n_cmp++; if ({start, state_in} !== {1'b1, 5'd2}) begin
      n_err++; $display("FAIL b2b_second: got %b/%0d want 1/2", start, state_in); end
    wait_for(0, 1'b0, n);
    pulse_done();
    n_cmp++; if ({result_id, result_timeout} !== {5'd2, 1'b0}) begin
      n_err++; $display("FAIL b2b_res2: got %0d/%b want 2/0", result_id, result_timeout); end
    wait_for(2, 1'b0, n);
    n_cmp++; if (n !== GAP_CYCLES) begin
      n_err++; $display("FAIL b2b_idle: got %0d want %0d", n, GAP_CYCLES); end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: sim time exceeded, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_queue_limits();
    test_simultaneous();
    test_reset_mid_launch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scenario_sequencer.md
Name: scenario_sequencer

Overview:
- Upstream stimulus stage for top_level. Queues 5-bit scenario IDs and launches each one in turn on top_level's state_in/start interface.
- For each scenario: holds state_in, pulses start for a fixed number of cycles, then waits for top_level's completion pulse or a timeout.
- Reports the scenario ID and outcome per launch. Replaces hand-timed start/state_in sequencing in benches and on-board bring-up.

Parameters:
- DEPTH, 4: scenario queue entries (power of 2).
- START_CYCLES, 2: cycles start is held high (40 ns at 20 ns clock).
- TIMEOUT, 3200: WAIT cycles before a scenario is declared timed out (64 us at 20 ns).
- GAP_CYCLES, 25: idle cycles after each completion before the next launch.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- push  input  1  enqueue push_id this cycle.
- push_id  input  5  scenario ID; 0 is reserved (idle) and is never enqueued.
- full  output  1  queue holds DEPTH entries.
- empty  output  1  queue holds 0 entries.
- drop_err  output  1  one-cycle pulse: push rejected (queue full, or ID 0).
- start  output  1  start strobe to top_level.
- state_in  output  5  scenario select to top_level.
- done_in  input  1  completion pulse from top_level.
- busy  output  1  high in LAUNCH, WAIT or GAP.
- result_valid  output  1  one-cycle pulse when a scenario finishes.
- result_id  output  5  ID of the finished scenario; held until the next result.
- result_timeout  output  1  1 = finished by timeout, 0 = done_in seen; held with result_id.

Behaviour:
- Reset (reset=0, async): all outputs 0 (state_in=0, start=0, busy=0, result_*=0, drop_err=0). empty=1, full=0. Queue flushed, FSM to IDLE, counters cleared. If reset is asserted mid-LAUNCH, start drops immediately without waiting for a clock edge. Release is synchronous to the next clk edge.
- Queue is a DEPTH-entry FIFO with 3-bit occupancy count (log2(DEPTH)+1 bits). Flags are registered and exact.
- Push handling:
  - push with push_id=0: ignored, drop_err=1.
  - push while full: ignored, drop_err=1, unless a pop occurs in the same cycle, in which case the push is accepted.
  - Push into an empty queue has no bypass; the entry becomes poppable on the next cycle.
- FSM states are IDLE, LAUNCH, WAIT, GAP.
- IDLE, queue non-empty: pop the head. On the same edge set state_in<=head, start<=1, cnt<=0, go to LAUNCH. Latency from push into an empty idle block to start=1 is 2 cycles.
- LAUNCH: start stays high for exactly START_CYCLES cycles, then start<=0, timer<=0, go to WAIT. done_in is ignored in LAUNCH.
- WAIT: timer increments each cycle.
  - done_in=1: result_valid=1, result_timeout=0, result_id=state_in, go to GAP.
  - timer==TIMEOUT-1 with no done_in: result_valid=1, result_timeout=1, go to GAP.
  - done_in on the same cycle as timer expiry: done wins (result_timeout=0).
- GAP: GAP_CYCLES cycles, then IDLE. state_in stays at the last ID through GAP and IDLE and changes only at the next launch. It never returns to 0 except on reset.
- busy=1 in LAUNCH, WAIT and GAP.
- Timer width is clog2(TIMEOUT). No wrap is possible because the timer exits at TIMEOUT-1.
- Pushes are accepted in every state. The queue is independent of the FSM.

Test Plan:
- Use START_CYCLES=2, TIMEOUT=16, GAP_CYCLES=4, DEPTH=4 unless noted.
- 1. Basic launch: reset low 2 cycles then high; push id=1. Expect start=1 on exactly 2 cycles starting 2 cycles after push, and state_in=1. Pulse done_in 5 cycles later. Expect result_valid for 1 cycle with result_id=1, result_timeout=0, then busy=0 after 4 GAP cycles.
- 2. Timeout: push id=9, never assert done_in. Expect result_valid exactly 16 cycles after start falls, with result_id=9, result_timeout=1.
- 3. Queue limits: while busy on id=2, push 10,3,4,5 (full=1), then push 6. Expect drop_err pulse and 6 absent. IDs launch in order 10,3,4,5. Push of id=0 gives drop_err and no launch.
- 4. Simultaneous events: done_in on the timer's final cycle gives result_timeout=0. Push while full on the IDLE pop cycle is accepted, with no drop_err.
- 5. Reset mid-LAUNCH: assert reset between clock edges while start=1. Expect start=0 immediately, state_in=0, empty=1. After release with no pushes, expect no further start.
- 6. Back-to-back: push 1,2 into idle. Expect second start exactly START_CYCLES+wait+GAP_CYCLES+1 cycles after the first result_valid sequence. state_in holds 1 through GAP, then switches to 2 on the launch edge.
